// File: rtl/mem_arbiter.sv
// Two-port (fetch I / load-store D) arbiter and sequencer for the shared unified memory.
// Optional MEM_ARB_ALIGN_CHECK_EN: adds err output; misaligned accesses never modify memory.
module mem_arbiter #(
    parameter int M = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_req,
    input  logic [M+1:0] i_addr,
    output logic         i_gnt,
    output logic         i_rvalid,
    output logic [31:0]  i_rdata,
    input  logic         d_req,
    input  logic         d_we,
    input  logic [M+1:0] d_addr,
    input  logic [31:0]  d_mask,
    input  logic [31:0]  d_wdata,
    output logic         d_gnt,
    output logic         d_rvalid,
    output logic [31:0]  d_rdata,
`ifdef MEM_ARB_ALIGN_CHECK_EN
    output logic         err,
`endif
    output logic [M+1:0] mem_address,
    output logic [31:0]  mem_mask,
    output logic         mem_wf,
    output logic [31:0]  mem_w,
    input  logic [31:0]  mem_v
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {PORT_I, PORT_D} port_t;

    state_t       state, state_nx;
    port_t        last_grant, owner, winner;
    logic         owner_we;
    logic         arb_go;
    logic         win_we;
    logic [M+1:0] win_addr;
    logic         resp;
    logic         resp_data;
`ifdef MEM_ARB_ALIGN_CHECK_EN
    logic         win_bad;
    logic         owner_bad;
`endif

    // Arbitration happens on any edge not ending an ACCESS cycle (IDLE or RESP).
    always_comb begin
        winner = PORT_I;
        if (i_req && d_req)
            winner = (last_grant == PORT_I) ? PORT_D : PORT_I;
        else if (d_req)
            winner = PORT_D;
        arb_go   = (state != ACCESS) && (i_req || d_req);
        win_addr = (winner == PORT_D) ? d_addr : i_addr;
        win_we   = (winner == PORT_D) && d_we;
`ifdef MEM_ARB_ALIGN_CHECK_EN
        win_bad  = (win_addr[1:0] != 2'b00);
`endif
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (arb_go) state_nx = ACCESS;
            ACCESS:  state_nx = RESP;
            RESP:    state_nx = arb_go ? ACCESS : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant  <= PORT_D;
            owner       <= PORT_I;
            owner_we    <= 1'b0;
            i_gnt       <= 1'b0;
            d_gnt       <= 1'b0;
            mem_address <= '0;
            mem_mask    <= '0;
            mem_wf      <= 1'b0;
            mem_w       <= '0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
            owner_bad   <= 1'b0;
`endif
        end else if (arb_go) begin
            last_grant  <= winner;
            owner       <= winner;
            owner_we    <= win_we;
            i_gnt       <= (winner == PORT_I);
            d_gnt       <= (winner == PORT_D);
            mem_address <= win_addr;
            mem_mask    <= win_we ? d_mask : '0;
            mem_wf      <= win_we;
            mem_w       <= win_we ? d_wdata : '0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
            owner_bad   <= win_bad;
            if (win_bad) begin
                mem_mask <= '0;
                mem_wf   <= 1'b0;
            end
`endif
        end else if (state == ACCESS) begin
            i_gnt  <= 1'b0;
            d_gnt  <= 1'b0;
            mem_wf <= 1'b0;
        end
    end

    always_comb begin
        resp      = (state == RESP);
        i_rvalid  = resp && (owner == PORT_I);
        d_rvalid  = resp && (owner == PORT_D);
        resp_data = !owner_we;
`ifdef MEM_ARB_ALIGN_CHECK_EN
        resp_data = resp_data && !owner_bad;
        err       = resp && owner_bad;
`endif
        i_rdata   = (i_rvalid && resp_data) ? mem_v : '0;
        d_rdata   = (d_rvalid && resp_data) ? mem_v : '0;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: memory stub, directed scenarios, randomized traffic vs a
// transaction-level model. Define MEM_ARB_ALIGN_CHECK_EN to also exercise the err feature.
module tb_mem_arbiter;
    localparam int M  = 10;
    localparam int AW = M + 2;

    logic          clk;
    logic          rst_n;
    logic          i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [31:0]   d_mask, d_wdata;
    logic          i_gnt, i_rvalid, d_gnt, d_rvalid;
    logic [31:0]   i_rdata, d_rdata;
    logic [AW-1:0] mem_address;
    logic [31:0]   mem_mask, mem_w, mem_v;
    logic          mem_wf;
`ifdef MEM_ARB_ALIGN_CHECK_EN
    logic          err;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] stub_mem [0:(1<<M)-1];
    logic [31:0] ref_mem  [0:(1<<M)-1];
    logic        mdl_last_d;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter #(.M(M)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_mask(d_mask), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
`ifdef MEM_ARB_ALIGN_CHECK_EN
        .err(err),
`endif
        .mem_address(mem_address), .mem_mask(mem_mask), .mem_wf(mem_wf), .mem_w(mem_w),
        .mem_v(mem_v)
    );

    // Memory stub: 1-cycle registered read, bit-masked write.
    always @(posedge clk) begin
        if (mem_wf)
            stub_mem[mem_address[AW-1:2]] <= (stub_mem[mem_address[AW-1:2]] & ~mem_mask) | (mem_w & mem_mask);
        mem_v <= stub_mem[mem_address[AW-1:2]];
    end

    function automatic void ref_write(input logic [AW-1:0] a, input logic [31:0] m, input logic [31:0] w);
        ref_mem[a[AW-1:2]] = (ref_mem[a[AW-1:2]] & ~m) | (w & m);
    endfunction

    function automatic logic [31:0] ref_read(input logic [AW-1:0] a);
        return ref_mem[a[AW-1:2]];
    endfunction

    task automatic idle_inputs();
        i_req = 0; i_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_mask = '0; d_wdata = '0;
    endtask

    task automatic d_txn(input logic we, input logic [AW-1:0] a, input logic [31:0] m, input logic [31:0] w,
                         output logic g1, output logic og1, output logic wf1,
                         output logic rv2, output logic [31:0] rd2);
        d_req = 1; d_we = we; d_addr = a; d_mask = m; d_wdata = w;
        @(negedge clk);
        g1 = d_gnt; og1 = i_gnt; wf1 = mem_wf;
        @(negedge clk);
        rv2 = d_rvalid; rd2 = d_rdata;
        d_req = 0; d_we = 0;
        mdl_last_d = 1;
    endtask

    task automatic i_txn(input logic [AW-1:0] a, output logic g1, output logic rv2, output logic [31:0] rd2);
        i_req = 1; i_addr = a;
        @(negedge clk);
        g1 = i_gnt;
        @(negedge clk);
        rv2 = i_rvalid; rd2 = i_rdata;
        i_req = 0;
        mdl_last_d = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        total++;
        if ({i_gnt, d_gnt, i_rvalid, d_rvalid, mem_wf} !== 5'b0) begin
            bad++; $display("FAIL reset_ctl got=%b want=00000", {i_gnt, d_gnt, i_rvalid, d_rvalid, mem_wf});
        end
        total++;
        if ({i_rdata, d_rdata} !== 64'h0) begin
            bad++; $display("FAIL reset_rdata got=%h/%h want=0/0", i_rdata, d_rdata);
        end
        total++;
        if ({mem_address, mem_mask, mem_w} !== '0) begin
            bad++; $display("FAIL reset_mem got=%h/%h/%h want=0", mem_address, mem_mask, mem_w);
        end
`ifdef MEM_ARB_ALIGN_CHECK_EN
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
`endif
        rst_n = 1;
        mdl_last_d = 1;
        @(negedge clk);
        i_req = 1; i_addr = 'h40; d_req = 1; d_we = 0; d_addr = 'h80;
        @(negedge clk);
        total++;
        if ({i_gnt, d_gnt} !== 2'b10) begin bad++; $display("FAIL first_tie got=%b want=10", {i_gnt, d_gnt}); end
        @(negedge clk);
        total++;
        if ({i_rvalid, d_rvalid} !== 2'b10 || i_rdata !== ref_read('h40)) begin
            bad++; $display("FAIL tie_i_resp got=%b/%h want=10/%h", {i_rvalid, d_rvalid}, i_rdata, ref_read('h40));
        end
        i_req = 0;
        @(negedge clk);
        total++;
        if ({i_gnt, d_gnt} !== 2'b01) begin bad++; $display("FAIL tie_d_next got=%b want=01", {i_gnt, d_gnt}); end
        @(negedge clk);
        total++;
        if (d_rvalid !== 1'b1 || d_rdata !== ref_read('h80)) begin
            bad++; $display("FAIL tie_d_resp got=%b/%h want=1/%h", d_rvalid, d_rdata, ref_read('h80));
        end
        d_req = 0;
        mdl_last_d = 1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        logic g, og, wf, rv;
        logic [31:0] rd;
        d_txn(1, 'h10, 32'hFFFFFFFF, 32'hDEADBEEF, g, og, wf, rv, rd);
        ref_write('h10, 32'hFFFFFFFF, 32'hDEADBEEF);
        total++;
        if ({g, og, wf} !== 3'b101) begin bad++; $display("FAIL wr_gnt_c1 got=%b want=101", {g, og, wf}); end
        total++;
        if (rv !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL wr_ack_c2 got=%b/%h want=1/0", rv, rd); end
        i_txn('h10, g, rv, rd);
        total++;
        if (g !== 1'b1 || rv !== 1'b1) begin bad++; $display("FAIL i_rd_timing got=%b%b want=11", g, rv); end
        total++;
        if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL i_rd_data got=%h want=deadbeef", rd); end
    endtask

    task automatic test_partial_write();
        logic g, og, wf, rv;
        logic [31:0] rd;
        d_txn(1, 'h10, 32'h0000FF00, 32'h00001200, g, og, wf, rv, rd);
        ref_write('h10, 32'h0000FF00, 32'h00001200);
        d_txn(0, 'h10, '0, '0, g, og, wf, rv, rd);
        total++;
        if (wf !== 1'b0 || rv !== 1'b1 || rd !== 32'hDEAD12EF) begin
            bad++; $display("FAIL partial_rd got=wf%b rv%b %h want=wf0 rv1 dead12ef", wf, rv, rd);
        end
        d_txn(1, 'h10, 32'h0, 32'h55555555, g, og, wf, rv, rd);
        total++;
        if ({g, wf, rv} !== 3'b111 || rd !== 32'h0) begin
            bad++; $display("FAIL mask0_ack got=%b%b%b/%h want=111/0", g, wf, rv, rd);
        end
        d_txn(0, 'h10, '0, '0, g, og, wf, rv, rd);
        total++;
        if (rd !== 32'hDEAD12EF) begin bad++; $display("FAIL mask0_unchanged got=%h want=dead12ef", rd); end
    endtask

    task automatic test_back_to_back();
        logic exp_d;
        logic [31:0] want;
        exp_d = ~mdl_last_d;
        i_req = 1; i_addr = 'h10;
        d_req = 1; d_we = 0; d_addr = 'h20;
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            total++;
            if (i_gnt && d_gnt) begin bad++; $display("FAIL b2b_both_gnt cycle=%0d got=11 want=one", j); end
            total++;
            if (i_rvalid && d_rvalid) begin bad++; $display("FAIL b2b_both_rvalid cycle=%0d got=11 want=one", j); end
            if (j % 2 == 1) begin
                total++;
                if ({i_gnt, d_gnt} !== (exp_d ? 2'b01 : 2'b10)) begin
                    bad++; $display("FAIL b2b_gnt cycle=%0d got=%b want=%b", j, {i_gnt, d_gnt}, exp_d ? 2'b01 : 2'b10);
                end
            end else begin
                want = exp_d ? ref_read('h20) : ref_read('h10);
                total++;
                if ({i_rvalid, d_rvalid} !== (exp_d ? 2'b01 : 2'b10) || (exp_d ? d_rdata : i_rdata) !== want) begin
                    bad++; $display("FAIL b2b_resp cycle=%0d got=%b/%h/%h want=%b/%h", j,
                                    {i_rvalid, d_rvalid}, i_rdata, d_rdata, exp_d ? 2'b01 : 2'b10, want);
                end
                mdl_last_d = exp_d;
                exp_d = ~exp_d;
            end
        end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        logic g, rv;
        logic [31:0] rd;
        d_req = 1; d_we = 0; d_addr = 'h10;
        @(negedge clk);
        total++;
        if (d_gnt !== 1'b1) begin bad++; $display("FAIL mid_pre_gnt got=%b want=1", d_gnt); end
        rst_n = 0;
        d_req = 0;
        #1;
        total++;
        if (d_gnt !== 1'b0 || mem_address !== '0) begin
            bad++; $display("FAIL mid_async got=%b/%h want=0/0", d_gnt, mem_address);
        end
        @(negedge clk);
        total++;
        if ({d_rvalid, i_rvalid, mem_wf} !== 3'b000) begin
            bad++; $display("FAIL mid_no_rvalid got=%b want=000", {d_rvalid, i_rvalid, mem_wf});
        end
        rst_n = 1;
        mdl_last_d = 1;
        @(negedge clk);
        total++;
        if ({i_gnt, d_gnt, mem_wf} !== 3'b000) begin bad++; $display("FAIL mid_idle got=%b want=000", {i_gnt, d_gnt, mem_wf}); end
        i_txn('h10, g, rv, rd);
        total++;
        if ({g, rv} !== 2'b11 || rd !== ref_read('h10)) begin
            bad++; $display("FAIL mid_after_i got=%b%b/%h want=11/%h", g, rv, rd, ref_read('h10));
        end
    endtask

    task automatic test_random();
        int free_at;
        int gnt_cyc, rv_cyc;
        logic gnt_d, rv_d, pick_d;
        logic [31:0] rv_data;
        logic i_pend, i_done, d_pend, d_done, stop;
        logic exp_ig, exp_dg, exp_ir, exp_dr;
        logic [31:0] exp_ird, exp_drd;
        free_at = 0; gnt_cyc = -10; rv_cyc = -10;
        gnt_d = 0; rv_d = 0; rv_data = '0;
        i_pend = 0; i_done = 0; d_pend = 0; d_done = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            exp_ig  = (gnt_cyc == k) && !gnt_d;
            exp_dg  = (gnt_cyc == k) && gnt_d;
            exp_ir  = (rv_cyc == k) && !rv_d;
            exp_dr  = (rv_cyc == k) && rv_d;
            exp_ird = exp_ir ? rv_data : 32'h0;
            exp_drd = exp_dr ? rv_data : 32'h0;
            total++;
            if ({i_gnt, d_gnt, i_rvalid, d_rvalid} !== {exp_ig, exp_dg, exp_ir, exp_dr}) begin
                bad++; $display("FAIL rand_ctl cycle=%0d got=%b want=%b", k,
                                {i_gnt, d_gnt, i_rvalid, d_rvalid}, {exp_ig, exp_dg, exp_ir, exp_dr});
            end
            total++;
            if (i_rdata !== exp_ird || d_rdata !== exp_drd) begin
                bad++; $display("FAIL rand_rdata cycle=%0d got=%h/%h want=%h/%h", k, i_rdata, d_rdata, exp_ird, exp_drd);
            end
`ifdef MEM_ARB_ALIGN_CHECK_EN
            total++;
            if (err !== 1'b0) begin bad++; $display("FAIL rand_err cycle=%0d got=%b want=0", k, err); end
`endif
            stop = (k >= 380);
            if (exp_ig) i_done = 1;
            else begin
                if (i_done) begin i_pend = 0; i_done = 0; end
                if (!i_pend && !stop && $urandom_range(0, 2) != 0) begin
                    i_pend = 1;
                    i_addr = AW'($urandom_range(0, 15) << 2);
                end
            end
            if (exp_dg) d_done = 1;
            else begin
                if (d_done) begin d_pend = 0; d_done = 0; end
                if (!d_pend && !stop && $urandom_range(0, 2) != 0) begin
                    d_pend  = 1;
                    d_we    = 1'($urandom_range(0, 1));
                    d_addr  = AW'($urandom_range(0, 15) << 2);
                    d_mask  = $urandom;
                    d_wdata = $urandom;
                end
            end
            i_req = i_pend;
            d_req = d_pend;
            if (k >= free_at && (i_pend || d_pend)) begin
                pick_d     = (i_pend && d_pend) ? !mdl_last_d : d_pend;
                mdl_last_d = pick_d;
                gnt_cyc = k + 1; gnt_d = pick_d;
                rv_cyc  = k + 2; rv_d  = pick_d;
                free_at = k + 2;
                if (pick_d && d_we) begin
                    ref_write(d_addr, d_mask, d_wdata);
                    rv_data = 32'h0;
                end else begin
                    rv_data = pick_d ? ref_read(d_addr) : ref_read(i_addr);
                end
            end
        end
        idle_inputs();
        @(negedge clk);
    endtask

`ifdef MEM_ARB_ALIGN_CHECK_EN
    task automatic test_align();
        logic g, e1, e2, rv2, wf_seen;
        logic [31:0] rd2;
        logic [31:0] want;
        logic gi, rvi;
        logic [31:0] rdi;
        want = ref_read('h10);
        d_req = 1; d_we = 1; d_addr = 'h13; d_mask = 32'hFFFFFFFF; d_wdata = 32'hAAAAAAAA;
        @(negedge clk);
        g = d_gnt; e1 = err; wf_seen = mem_wf;
        @(negedge clk);
        rv2 = d_rvalid; rd2 = d_rdata; e2 = err; wf_seen = wf_seen | mem_wf;
        idle_inputs();
        mdl_last_d = 1;
        total++;
        if ({g, e1} !== 2'b10) begin bad++; $display("FAIL align_c1 got=%b want=10", {g, e1}); end
        total++;
        if ({rv2, e2} !== 2'b11 || rd2 !== 32'h0) begin
            bad++; $display("FAIL align_c2 got=%b/%h want=11/0", {rv2, e2}, rd2);
        end
        total++;
        if (wf_seen !== 1'b0) begin bad++; $display("FAIL align_wf got=%b want=0", wf_seen); end
        i_txn('h10, gi, rvi, rdi);
        total++;
        if (rdi !== want) begin bad++; $display("FAIL align_unchanged got=%h want=%h", rdi, want); end
    endtask
`endif

    initial begin
        for (int n = 0; n < (1 << M); n++) begin
            stub_mem[n] = '0;
            ref_mem[n]  = '0;
        end
        mdl_last_d = 1;
        test_reset();
        test_write_read();
        test_partial_write();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
`ifdef MEM_ARB_ALIGN_CHECK_EN
        test_align();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
